// File: rtl/batch_arb_pkg.sv
// Shared types for the batch arbiter: FSM state encoding and the select-width helper.
package batch_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_FOLDS = 2;

  // A 2-requester arbiter still needs one select bit.
  function automatic int selWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/batch_arbiter_if.sv
// Requester handshake plus mux-select bundle between the arbiter and the shared datapath.
interface batch_arbiter_if #(
  parameter int WIDTH = batch_arb_pkg::DEFAULT_WIDTH,
  parameter int FOLDS = batch_arb_pkg::DEFAULT_FOLDS,
  parameter int SW    = batch_arb_pkg::selWidth(WIDTH)
);

  logic [WIDTH-1:0]         i_valid;
  logic                     i_stall;
  logic [WIDTH-1:0]         o_ready;
  logic [FOLDS-1:0][SW-1:0] o_sel;
  logic [FOLDS-1:0]         o_sel_vld;
  logic                     o_busy;
  logic                     o_batch_done;

  modport slave (
    input  i_valid, i_stall,
    output o_ready, o_sel, o_sel_vld, o_busy, o_batch_done
  );

  modport master (
    output i_valid, i_stall,
    input  o_ready, o_sel, o_sel_vld, o_busy, o_batch_done
  );

endinterface

// File: rtl/batch_arbiter_rr_pick.sv
// One round-robin lane: picks the first set mask bit at or after ptr (wrapping) and
// returns the mask with that bit cleared so the next lane can continue the scan.
module rr_pick #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic [WIDTH-1:0] mask_i,
  input  logic [SW-1:0]    ptr_i,
  output logic [SW-1:0]    code_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] mask_o
);

  always_comb begin
    int          raw;
    logic [SW-1:0] idx;
    code_o = '0;
    vld_o  = 1'b0;
    mask_o = mask_i;
    raw    = 0;
    idx    = '0;
    // Index arithmetic is done in int so WIDTH need not be a power of two.
    for (int i = 0; i < WIDTH; i++) begin
      raw = int'(ptr_i) + i;
      if (raw >= WIDTH) raw = raw - WIDTH;
      idx = SW'(raw);
      if (!vld_o && mask_i[idx]) begin
        vld_o       = 1'b1;
        code_o      = idx;
        mask_o[idx] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/batch_arbiter.sv
// Batch arbiter: snapshots pending requests, then grants up to FOLDS of them per cycle
// in round-robin order until the batch drains.
module batch_arbiter
  import batch_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int FOLDS = DEFAULT_FOLDS
) (
  input logic             i_clk,
  input logic             i_rst_n,
  batch_arbiter_if.slave  bus
);

  localparam int SW = selWidth(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q,  pend_d;
  logic [SW-1:0]    ptr_q,   ptr_d;

  logic [WIDTH-1:0]         eff;
  logic [FOLDS:0][WIDTH-1:0] chain;
  logic [FOLDS-1:0][SW-1:0] laneCode;
  logic [FOLDS-1:0]         laneVld;
  logic [WIDTH-1:0]         remaining;
  logic [WIDTH-1:0]         granted;
  logic                     anyGrant;
  logic                     serving;
  logic [SW-1:0]            lastIdx;
  logic [SW-1:0]            nextPtr;

  // Withdrawn requesters fall out of the batch the moment they drop valid.
  assign eff      = pend_q & bus.i_valid;
  assign chain[0] = eff;

  for (genvar k = 0; k < FOLDS; k++) begin : gLane
    rr_pick #(
      .WIDTH (WIDTH),
      .SW    (SW)
    ) uPick (
      .mask_i (chain[k]),
      .ptr_i  (ptr_q),
      .code_o (laneCode[k]),
      .vld_o  (laneVld[k]),
      .mask_o (chain[k+1])
    );
  end

  assign remaining = chain[FOLDS];
  assign granted   = eff & ~remaining;
  assign anyGrant  = |laneVld;
  assign serving   = (state_q == SERVE) && !bus.i_stall;

  // Lanes fill in order, so the highest valid lane holds the last index granted.
  always_comb begin
    lastIdx = '0;
    for (int k = 0; k < FOLDS; k++) begin
      if (laneVld[k]) lastIdx = laneCode[k];
    end
  end

  assign nextPtr = (lastIdx == SW'(WIDTH - 1)) ? '0 : lastIdx + SW'(1);

  always_comb begin
    bus.o_ready      = serving ? granted : '0;
    bus.o_busy       = (state_q == SERVE);
    bus.o_batch_done = serving && (remaining == '0) && anyGrant;
    for (int k = 0; k < FOLDS; k++) begin
      bus.o_sel_vld[k] = serving && laneVld[k];
      bus.o_sel[k]     = (serving && laneVld[k]) ? laneCode[k] : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.i_valid) begin
          pend_d  = bus.i_valid;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (bus.i_stall) begin
          pend_d = eff;
        end else begin
          pend_d = remaining;
          if (remaining == '0) begin
            state_d = IDLE;
            if (anyGrant) ptr_d = nextPtr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
